dump_gate_drv: RTL and testbench
================================

// Module: dump_gate_drv
// PURPOSE
//  Downstream stage of the DUMP sequencer: turns its dump_on/dump_off requests into the two
//  gate drives of the NMR antenna dump (Q-damp) switches.
//  Guarantees q_on/q_off are never high together, inserts programmable dead-time on every
//  switch exit, bounds q_on time with a watchdog, and latches external/watchdog faults.
//  Sits between DUMP and the dump H-bridge pins, clocked by clk_sys (10 MHz).
// PARAMETERS
//  DEAD_W       8        width of dead-time count (cycles)
//  WDOG_W       16       width of max-on watchdog count (cycles)
//  DEAD_DEFAULT 8'd10    dead-time after reset (1.0 us)
//  WDOG_DEFAULT 16'd5000 max q_on time after reset (500 us); 0 = watchdog disabled
// PORTS
//  clk_sys     in  1       system clock
//  rst         in  1       synchronous reset, active-high
//  dump_on     in  1       level request from DUMP: close damp switch
//  dump_off    in  1       level request from DUMP: close discharge switch
//  dead_load   in  1       1-cycle strobe: latch dead_para
//  dead_para   in  DEAD_W  new dead-time, cycles (0 treated as 1)
//  wdog_load   in  1       1-cycle strobe: latch wdog_para
//  wdog_para   in  WDOG_W  new max-on time, cycles
//  fault_in    in  1       external overcurrent, active-high, asynchronous to clk_sys
//  fault_clr   in  1       1-cycle strobe: clear latched fault
//  q_on        out 1       damp switch gate
//  q_off       out 1       discharge switch gate
//  busy        out 1       state != IDLE
//  fault       out 1       state == FAULT
//  fault_code  out 2       00 none, 01 external, 10 watchdog; held until cleared
// BEHAVIOUR
//  - All outputs registered; rst at any edge (incl. mid-pulse) -> all outputs 0 next edge,
//    state IDLE, dead_reg=DEAD_DEFAULT, wdog_reg=WDOG_DEFAULT, counters 0.
//  - States: IDLE, ON, OFF, DEAD, FAULT. q_on=1 only in ON, q_off=1 only in OFF.
//  - Request decode: on-only -> ON; off-only -> OFF; both or neither -> IDLE.
//  - IDLE: decoded request applied at the edge it is sampled; output is high 1 cycle later.
//  - ON/OFF: leave when the decoded request changes -> DEAD (both gates low from next cycle).
//  - DEAD: counter loaded with max(dead_reg,1) on entry; both low exactly that many cycles;
//    at expiry re-decode requests and go to ON, OFF or IDLE. Never ON<->OFF directly.
//  - Watchdog: on ON entry counter loaded with wdog_reg; it decrements each ON cycle;
//    reaching 0 while still ON (wdog_reg!=0) -> FAULT, fault_code=10. Exact limit: q_on high
//    for wdog_reg cycles max.
//  - fault_in (after sync) high in any state -> FAULT next edge, fault_code=01; has priority
//    over the watchdog on the same edge.
//  - FAULT: both gates low; exit only on fault_clr with synced fault_in low -> DEAD (full
//    dead-time), fault_code->00. fault_clr while fault_in high is ignored.
//  - dead_load/wdog_load take effect at the next DEAD/ON entry; a running count is unaffected.
//    Load and use on the same edge: the old value is used.
// CONFIGURATION
//  DUMP_DRV_FAULT_SYNC_EN defined: fault_in through a 2-flop synchronizer; FAULT entered
//    3 edges after fault_in rises.
//  Not defined: fault_in registered once; FAULT entered 2 edges after rise (sync source only).
// STRUCTURE
//  Package dump_drv_pkg: state encoding localparams, fault_code constants, DEAD_DEFAULT and
//  WDOG_DEFAULT values.
//  Sub-module dump_drv_cnt: parameterised loadable down-counter (load, en, zero flag),
//  instantiated twice (dead-time, watchdog). FSM and output registers in the top.
// TESTING
//  1 dump_on=1 from IDLE, dead=10 -> q_on high 1 cycle later; drop dump_on -> q_on low next
//    cycle, busy high for 10 more cycles, then IDLE.
//  2 dump_on 1->0 with dump_off 0->1 same cycle -> q_on low, exactly 10 cycles both low,
//    then q_off high; q_on&q_off never 1 (assertion over whole run).
//  3 dump_on and dump_off both 1 from IDLE -> both gates stay 0, state IDLE.
//  4 wdog_para=100 loaded, hold dump_on -> q_on high exactly 100 cycles, fault=1,
//    fault_code=10; fault_clr -> 10 dead cycles, then q_on again if dump_on still high.
//  5 pulse fault_in during OFF -> q_off low 3 (macro on) / 2 (macro off) edges later,
//    fault_code=01; fault_clr with fault_in high ignored; cleared once low.
//  6 rst asserted mid-ON and mid-DEAD -> outputs 0 next edge; dead_para loaded before reset
//    is lost, dead-time back to 10.

Source files
------------

// File: rtl/dump_drv_pkg.sv
// dump_drv_pkg: shared state encoding, fault codes and reset defaults for the
// DUMP gate driver.
package dump_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ON    = 3'd1,
        ST_OFF   = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_EXT  = 2'b01;
    localparam logic [1:0] FC_WDOG = 2'b10;

    // Dead-time 1.0 us and max-on 500 us at 10 MHz
    localparam int unsigned DEAD_DEFAULT_VAL = 10;
    localparam int unsigned WDOG_DEFAULT_VAL = 5000;

    // Map the two level requests onto the steady state they ask for
    function automatic state_t decode_req(input logic on_req, input logic off_req);
        if (on_req && !off_req) begin
            return ST_ON;
        end else if (off_req && !on_req) begin
            return ST_OFF;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/dump_drv_cnt.sv
// dump_drv_cnt: loadable down-counter; holds at zero, load wins over enable.
// Flags: zero (count is 0) and last (count is 1, expires on the next enabled edge).
module dump_drv_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    // Count register: load, else decrement while enabled and non-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // Status flags decoded from the current count
    always_comb begin
        zero = (cnt == '0);
        last = (cnt == W'(1));
    end

endmodule

// File: rtl/dump_gate_drv.sv
// dump_gate_drv: converts DUMP dump_on/dump_off requests into mutually exclusive
// q_on/q_off gate drives with dead-time, a max-on watchdog and latched faults.
// Optional macro DUMP_DRV_FAULT_SYNC_EN: fault_in passes a 2-flop synchronizer
// (default build registers it once).
module dump_gate_drv
    import dump_drv_pkg::*;
#(
    parameter int unsigned          DEAD_W       = 8,
    parameter int unsigned          WDOG_W       = 16,
    parameter logic [DEAD_W-1:0]    DEAD_DEFAULT = DEAD_W'(DEAD_DEFAULT_VAL),
    parameter logic [WDOG_W-1:0]    WDOG_DEFAULT = WDOG_W'(WDOG_DEFAULT_VAL)
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              dump_on,
    input  logic              dump_off,
    input  logic              dead_load,
    input  logic [DEAD_W-1:0] dead_para,
    input  logic              wdog_load,
    input  logic [WDOG_W-1:0] wdog_para,
    input  logic              fault_in,
    input  logic              fault_clr,
    output logic              q_on,
    output logic              q_off,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);

    state_t            state, state_nxt;
    state_t            req_st;
    logic [1:0]        code_nxt;
    logic [DEAD_W-1:0] dead_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic [DEAD_W-1:0] dead_init;
    logic              fault_s;
    logic              dead_ld, dead_en, dead_zero, dead_last, dead_done;
    logic              wdog_ld, wdog_en, wdog_zero, wdog_last, wdog_trip;

`ifdef DUMP_DRV_FAULT_SYNC_EN
    logic fault_meta;

    // Two-stage synchronizer for the asynchronous overcurrent input
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fault_meta <= 1'b0;
            fault_s    <= 1'b0;
        end else begin
            fault_meta <= fault_in;
            fault_s    <= fault_meta;
        end
    end
`else
    // Single capture register for a fault source already in the clk_sys domain
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fault_s <= 1'b0;
        end else begin
            fault_s <= fault_in;
        end
    end
`endif

    // Programmable dead-time and max-on registers; used at the next entry only
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            dead_reg <= DEAD_DEFAULT;
            wdog_reg <= WDOG_DEFAULT;
        end else begin
            if (dead_load) begin
                dead_reg <= dead_para;
            end
            if (wdog_load) begin
                wdog_reg <= wdog_para;
            end
        end
    end

    dump_drv_cnt #(.W(DEAD_W)) u_dead_cnt (
        .clk      (clk_sys),
        .rst      (rst),
        .load     (dead_ld),
        .en       (dead_en),
        .load_val (dead_init),
        .zero     (dead_zero),
        .last     (dead_last)
    );

    dump_drv_cnt #(.W(WDOG_W)) u_wdog_cnt (
        .clk      (clk_sys),
        .rst      (rst),
        .load     (wdog_ld),
        .en       (wdog_en),
        .load_val (wdog_reg),
        .zero     (wdog_zero),
        .last     (wdog_last)
    );

    // Counter control: load on state entry, count while resident
    always_comb begin
        dead_init = (dead_reg == '0) ? DEAD_W'(1) : dead_reg;
        dead_ld   = (state_nxt == ST_DEAD) && (state != ST_DEAD);
        dead_en   = (state == ST_DEAD);
        wdog_ld   = (state_nxt == ST_ON) && (state != ST_ON);
        wdog_en   = (state == ST_ON);
        // Exit on the last counted cycle; zero also exits so DEAD can never stall
        dead_done = dead_last || dead_zero;
        // A watchdog loaded with 0 stays at zero and never trips
        wdog_trip = wdog_last && !wdog_zero;
    end

    // Next-state and fault-code decode; external fault overrides everything
    always_comb begin
        state_nxt = state;
        code_nxt  = fault_code;
        req_st    = decode_req(dump_on, dump_off);
        case (state)
            ST_IDLE: begin
                state_nxt = req_st;
            end
            ST_ON: begin
                if (req_st != ST_ON) begin
                    state_nxt = ST_DEAD;
                end else if (wdog_trip) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_WDOG;
                end
            end
            ST_OFF: begin
                if (req_st != ST_OFF) begin
                    state_nxt = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (dead_done) begin
                    state_nxt = req_st;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fault_s) begin
                    state_nxt = ST_DEAD;
                    code_nxt  = FC_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (fault_s && (state != ST_FAULT)) begin
            state_nxt = ST_FAULT;
            code_nxt  = FC_EXT;
        end
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state      <= ST_IDLE;
            q_on       <= 1'b0;
            q_off      <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_nxt;
            q_on       <= (state_nxt == ST_ON);
            q_off      <= (state_nxt == ST_OFF);
            busy       <= (state_nxt != ST_IDLE);
            fault      <= (state_nxt == ST_FAULT);
            fault_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_dump_gate_drv.sv
// tb_dump_gate_drv: directed self-checking bench for dump_gate_drv.
module tb_dump_gate_drv;

`ifdef DUMP_DRV_FAULT_SYNC_EN
    localparam int FLT_LAT = 3;
`else
    localparam int FLT_LAT = 2;
`endif

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        dump_on = 1'b0, dump_off = 1'b0;
    logic        dead_load = 1'b0, wdog_load = 1'b0;
    logic [7:0]  dead_para = '0;
    logic [15:0] wdog_para = '0;
    logic        fault_in = 1'b0, fault_clr = 1'b0;
    logic        q_on, q_off, busy, fault;
    logic [1:0]  fault_code;

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    always #5 clk_sys = ~clk_sys;

    dump_gate_drv dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .dump_on    (dump_on),
        .dump_off   (dump_off),
        .dead_load  (dead_load),
        .dead_para  (dead_para),
        .wdog_load  (wdog_load),
        .wdog_para  (wdog_para),
        .fault_in   (fault_in),
        .fault_clr  (fault_clr),
        .q_on       (q_on),
        .q_off      (q_off),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 100) begin
            k++;
            step();
        end
        check(tag, busy, 0);
    endtask

    // Gates must never be driven together
    always @(negedge clk_sys) begin
        if (!rst) begin
            check("excl", q_on & q_off, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(2);
        check("rst_q_on", q_on, 0);
        check("rst_q_off", q_off, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        rst = 1'b0;
        step();

        // 1: on then off, default dead-time 10
        dump_on = 1'b1;
        step();
        check("t1_q_on", q_on, 1);
        check("t1_busy", busy, 1);
        step(3);
        check("t1_hold", q_on, 1);
        dump_on = 1'b0;
        step();
        check("t1_q_on_low", q_on, 0);
        check("t1_busy_dead", busy, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("t1_dead_cycles", n, 10);

        // 2: on -> off swap in one cycle
        dump_on = 1'b1;
        step(3);
        dump_on  = 1'b0;
        dump_off = 1'b1;
        step();
        check("t2_q_on", q_on, 0);
        check("t2_q_off", q_off, 0);
        n = 0;
        while (!q_off && n < 100) begin
            n++;
            step();
        end
        check("t2_both_low", n, 10);
        check("t2_q_off_high", q_off, 1);
        dump_off = 1'b0;
        step();
        check("t2_q_off_low", q_off, 0);
        wait_idle("t2_idle");

        // 3: both requests -> stay idle
        dump_on  = 1'b1;
        dump_off = 1'b1;
        step();
        check("t3_q_on", q_on, 0);
        check("t3_q_off", q_off, 0);
        check("t3_busy", busy, 0);
        step(3);
        check("t3_busy_hold", busy, 0);
        dump_on  = 1'b0;
        dump_off = 1'b0;
        step();

        // 4: watchdog at 100 cycles
        wdog_para = 16'd100;
        wdog_load = 1'b1;
        step();
        wdog_load = 1'b0;
        dump_on   = 1'b1;
        step();
        check("t4_q_on", q_on, 1);
        n = 0;
        while (q_on && n < 300) begin
            n++;
            step();
        end
        check("t4_on_cycles", n, 100);
        check("t4_fault", fault, 1);
        check("t4_code", fault_code, 2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("t4_clr_fault", fault, 0);
        check("t4_clr_code", fault_code, 0);
        n = 0;
        while (!q_on && n < 100) begin
            n++;
            step();
        end
        check("t4_dead_cycles", n, 10);
        check("t4_q_on_again", q_on, 1);
        dump_on = 1'b0;
        step();
        wait_idle("t4_idle");

        // 5: external fault during OFF
        dump_off = 1'b1;
        step(3);
        check("t5_q_off", q_off, 1);
        fault_in = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (q_off && n < 10);
        check("t5_latency", n, FLT_LAT);
        check("t5_fault", fault, 1);
        check("t5_code", fault_code, 1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("t5_clr_ignored", fault, 1);
        check("t5_code_held", fault_code, 1);
        fault_in = 1'b0;
        step(3);
        check("t5_latched", fault, 1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("t5_cleared", fault, 0);
        check("t5_code_clr", fault_code, 0);
        check("t5_busy_dead", busy, 1);
        n = 0;
        while (!q_off && n < 100) begin
            n++;
            step();
        end
        check("t5_dead_cycles", n, 10);
        dump_off = 1'b0;
        step();
        wait_idle("t5_idle");

        // 6: reset mid-ON and mid-DEAD loses loaded dead-time
        dead_para = 8'd20;
        dead_load = 1'b1;
        step();
        dead_load = 1'b0;
        dump_on   = 1'b1;
        step();
        check("t6_q_on", q_on, 1);
        rst     = 1'b1;
        dump_on = 1'b0;
        step();
        check("t6_rst_on_q_on", q_on, 0);
        check("t6_rst_on_busy", busy, 0);
        rst     = 1'b0;
        dump_on = 1'b1;
        step();
        dump_on = 1'b0;
        step(4);
        check("t6_in_dead", busy, 1);
        rst = 1'b1;
        step();
        check("t6_rst_dead_busy", busy, 0);
        check("t6_rst_dead_fault", fault, 0);
        rst     = 1'b0;
        dump_on = 1'b1;
        step();
        dump_on = 1'b0;
        step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("t6_dead_default", n, 10);

        // 7: dead_para 0 behaves as 1
        dead_para = 8'd0;
        dead_load = 1'b1;
        step();
        dead_load = 1'b0;
        dump_on   = 1'b1;
        step();
        dump_on = 1'b0;
        step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("t7_dead_zero", n, 1);

        // 8: load on the entry edge uses the old value, next entry uses the new one
        dump_on = 1'b1;
        step();
        dead_para = 8'd5;
        dead_load = 1'b1;
        dump_on   = 1'b0;
        step();
        dead_load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("t8_old_value", n, 1);
        dump_on = 1'b1;
        step();
        dump_on = 1'b0;
        step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check("t8_new_value", n, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
